// File: rtl/led_ctrl_pkg.sv
// Shared types and default timing for the key-driven LED source selector.
// Defaults assume a 50 MHz sys_clk.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CNT,
    ST_HELD,
    ST_REL_CNT
  } db_state_t;

  localparam int DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int DEF_LONG_CYC     = 50_000_000;
  localparam int DEF_SCAN_CYC     = 25_000_000;

  // A single-source-bit select is still one bit wide.
  function automatic int sel_width(input int n_src);
    return (n_src > 2) ? $clog2(n_src) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces an active-low key, classifying each press as short or long.
// Events are registered one-cycle strobes: 2 sync cycles + DEBOUNCE_CYC samples after the key settles.
module key_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic short_evt_o,
  output logic long_evt_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);
  // The sample that leaves IDLE/HELD counts as the first stable one.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 2);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

  logic [1:0]        sync_q;
  logic              key_s;
  db_state_t         state_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic [HOLD_W-1:0] hold_q;
  logic              long_flag_q;
  logic              short_q;
  logic              long_q;

  assign key_s       = sync_q[1];
  assign short_evt_o = short_q;
  assign long_evt_o  = long_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      db_cnt_q    <= '0;
      hold_q      <= '0;
      long_flag_q <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      short_q <= 1'b0;
      long_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!key_s) begin
            state_q  <= ST_PRESS_CNT;
            db_cnt_q <= '0;
          end
        end
        ST_PRESS_CNT: begin
          if (key_s) begin
            state_q  <= ST_IDLE;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q  <= ST_HELD;
            db_cnt_q <= '0;
            hold_q   <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (key_s) begin
            state_q  <= ST_REL_CNT;
            db_cnt_q <= '0;
          end else if (hold_q != HOLD_MAX) begin
            hold_q <= hold_q + 1'b1;
            if (hold_q == HOLD_LAST) begin
              long_q      <= 1'b1;
              long_flag_q <= 1'b1;
            end
          end
        end
        ST_REL_CNT: begin
          // A bounce back low resumes the hold count where it left off.
          if (!key_s) begin
            state_q  <= ST_HELD;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            hold_q      <= '0;
            short_q     <= !long_flag_q;
            long_flag_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/led_src_ctrl.sv
// Key-driven LED source selector: short press steps sel, long press toggles timed auto-scan.
// sel/auto_mode/key_pulse update one cycle after a debounce event; led_out lags sel by one cycle.
module led_src_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int  N_SRC        = 2,
  parameter int  DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int  LONG_CYC     = DEF_LONG_CYC,
  parameter int  SCAN_CYC     = DEF_SCAN_CYC,
  localparam int SEL_W        = sel_width(N_SRC)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             key_in,
  input  logic [N_SRC-1:0] src_in,
  output logic             led_out,
  output logic [SEL_W-1:0] sel,
  output logic             auto_mode,
  output logic             key_pulse
);

  localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_SRC - 1);

  logic              short_evt;
  logic              long_evt;
  logic [SEL_W-1:0]  sel_q, sel_d, sel_inc;
  logic              auto_q, auto_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              pulse_q;
  logic              led_q;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .LONG_CYC     (LONG_CYC)
  ) u_key_debounce (
    .clk_i       (sys_clk),
    .rst_ni      (sys_rst_n),
    .key_i       (key_in),
    .short_evt_o (short_evt),
    .long_evt_o  (long_evt)
  );

  assign sel_inc = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

  // A short press outranks a coincident scan tick: auto exits and the tick is dropped.
  always_comb begin
    sel_d  = sel_q;
    auto_d = auto_q;
    scan_d = scan_q;
    if (short_evt) begin
      if (auto_q) auto_d = 1'b0;
      else        sel_d  = sel_inc;
      scan_d = '0;
    end else if (long_evt) begin
      auto_d = !auto_q;
      scan_d = '0;
    end else if (auto_q) begin
      if (scan_q == SCAN_LAST) begin
        scan_d = '0;
        sel_d  = sel_inc;
      end else begin
        scan_d = scan_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sel_q   <= '0;
      auto_q  <= 1'b0;
      scan_q  <= '0;
      pulse_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      auto_q  <= auto_d;
      scan_q  <= scan_d;
      pulse_q <= short_evt;
      led_q   <= src_in[sel_q];
    end
  end

  assign sel       = sel_q;
  assign auto_mode = auto_q;
  assign key_pulse = pulse_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_led_src_ctrl.sv
// Directed bench for led_src_ctrl: debounce, short/long press, auto-scan and mux latency.
// Inputs change and outputs are sampled on the falling edge of sys_clk.
module tb_led_src_ctrl;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_in    = 1'b1;
  logic [3:0] src_in    = 4'h0;
  logic       led_out;
  logic [1:0] sel;
  logic       auto_mode;
  logic       key_pulse;

  logic       key2 = 1'b1;
  logic [1:0] src2 = 2'b00;
  logic       led2;
  logic       sel2;
  logic       auto2;
  logic       pulse2;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses;
  int first_pulse;
  int auto_rise;

  always #5 sys_clk = ~sys_clk;

  led_src_ctrl #(
    .N_SRC(4), .DEBOUNCE_CYC(4), .LONG_CYC(20), .SCAN_CYC(8)
  ) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .src_in    (src_in),
    .led_out   (led_out),
    .sel       (sel),
    .auto_mode (auto_mode),
    .key_pulse (key_pulse)
  );

  led_src_ctrl #(
    .N_SRC(2), .DEBOUNCE_CYC(4), .LONG_CYC(20), .SCAN_CYC(8)
  ) u_dut2 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key2),
    .src_in    (src2),
    .led_out   (led2),
    .sel       (sel2),
    .auto_mode (auto2),
    .key_pulse (pulse2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n falling edges, logging key_pulse and the first auto_mode rise.
  task automatic step(input int n, input int base);
    for (int i = 1; i <= n; i++) begin
      @(negedge sys_clk);
      if (key_pulse === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = base + i;
      end
      if (auto_mode === 1'b1 && auto_rise < 0) auto_rise = base + i;
    end
  endtask

  task automatic press(input int lo, input int hi);
    pulses      = 0;
    first_pulse = -1;
    auto_rise   = (auto_mode === 1'b1) ? 0 : -1;
    key_in = 1'b0;
    step(lo, 0);
    key_in = 1'b1;
    step(hi, lo);
  endtask

  initial begin
    int   sel_rise;
    int   cnt2;
    logic led_a;
    logic led_b;

    // Reset with key held low and all sources high.
    key_in = 1'b0;
    src_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check("rst_sel", sel, 0);
      check("rst_auto", auto_mode, 0);
      check("rst_led", led_out, 0);
      check("rst_pulse", key_pulse, 0);
    end
    sys_rst_n = 1'b1;

    // Key low only 3 cycles after reset: not a press.
    pulses = 0; first_pulse = -1; auto_rise = -1;
    step(3, 0);
    key_in = 1'b1;
    step(10, 3);
    check("post_rst_no_pulse", pulses, 0);
    check("post_rst_sel", sel, 0);
    check("led_src0", led_out, 1);

    // Bounce: 3 low, 1 high, 3 low.
    pulses = 0;
    key_in = 1'b0; step(3, 0);
    key_in = 1'b1; step(1, 0);
    key_in = 1'b0; step(3, 0);
    key_in = 1'b1; step(10, 0);
    check("bounce_pulse", pulses, 0);
    check("bounce_sel", sel, 0);

    // Exactly DEBOUNCE_CYC low samples is a valid press.
    press(4, 10);
    check("min_press_pulse", pulses, 1);
    check("min_press_at", first_pulse, 11);
    check("min_press_sel", sel, 1);

    press(10, 10);
    check("short_pulse", pulses, 1);
    check("short_at", first_pulse, 17);
    check("short_sel", sel, 2);
    press(10, 10);
    check("short_sel3", sel, 3);
    press(10, 10);
    check("wrap_pulse", pulses, 1);
    check("wrap_sel", sel, 0);

    // Long press from sel=0: auto at 27, scan ticks at 35, 43, 51, 59.
    press(40, 10);
    check("long_auto_at", auto_rise, 27);
    check("long_no_pulse", pulses, 0);
    check("long_auto", auto_mode, 1);
    check("scan_sel_50", sel, 2);
    step(1, 0);
    check("scan_sel_51", sel, 3);
    step(7, 0);
    check("scan_sel_58", sel, 3);
    step(1, 0);
    check("scan_wrap_59", sel, 0);

    // Short press in auto: confirmed at 76, after the tick at 75 set sel=2.
    press(10, 10);
    check("exit_pulse", pulses, 1);
    check("exit_at", first_pulse, 17);
    check("exit_auto", auto_mode, 0);
    check("exit_sel", sel, 2);
    step(10, 0);
    check("exit_sel_hold", sel, 2);
    check("exit_auto_hold", auto_mode, 0);

    // Re-enter auto (sel 2 -> 3 at 35, 0 at 43); short confirm lands on tick 67.
    press(40, 10);
    check("reauto_at", auto_rise, 27);
    check("reauto_sel", sel, 0);
    press(10, 10);
    check("tick_exit_pulse", pulses, 1);
    check("tick_exit_at", first_pulse, 17);
    check("tick_exit_auto", auto_mode, 0);
    check("tick_exit_sel", sel, 2);

    // Mux path on the two-source instance.
    src2 = 2'b10;
    step(2, 0);
    check("mux_led_src0", led2, 0);
    sel_rise = -1; cnt2 = 0; led_a = 1'bx; led_b = 1'bx;
    key2 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 11) key2 = 1'b1;
      @(negedge sys_clk);
      if (pulse2 === 1'b1) cnt2++;
      if (sel2 === 1'b1 && sel_rise < 0) sel_rise = i;
      if (i == 17) led_a = led2;
      if (i == 18) led_b = led2;
    end
    check("mux_sel_at", sel_rise, 17);
    check("mux_pulse2", cnt2, 1);
    check("mux_auto2", auto2, 0);
    check("mux_led_lag", led_a, 0);
    check("mux_led_new", led_b, 1);
    src2 = 2'b00;
    #1;
    check("mux_src_hold", led2, 1);
    @(negedge sys_clk);
    check("mux_src_fall", led2, 0);
    src2 = 2'b10;
    @(negedge sys_clk);
    check("mux_src_rise", led2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
